// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, ROM funct codes and instruction field layout for rom_sequencer.
package seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, ISSUE} state_e;
  // ALU functs all have bit 0 set; MOVE is the only even code that issues
  localparam logic [4:0] NULLS = 5'b00001;
  localparam logic [4:0] ONES  = 5'b00011;
  localparam logic [4:0] NO    = 5'b00101;
  localparam logic [4:0] NOT   = 5'b00111;
  localparam logic [4:0] XOR   = 5'b01001;
  localparam logic [4:0] XNOR  = 5'b01011;
  localparam logic [4:0] INCR  = 5'b01101;
  localparam logic [4:0] DECR  = 5'b01111;
  localparam logic [4:0] COMPL = 5'b10001;
  localparam logic [4:0] ADD   = 5'b10011;
  localparam logic [4:0] SUBTR = 5'b10101;
  localparam logic [4:0] MOVE  = 5'b11010;
  localparam int FUNCT_HI = 10;
  localparam int FUNCT_LO = 6;
  localparam int SRC_HI   = 5;
  localparam int SRC_LO   = 3;
  localparam int DST_HI   = 2;
  localparam int DST_LO   = 0;
  typedef struct packed {
    logic       is_alu;
    logic       is_move;
    logic       is_nop;
    logic [4:0] funct;
    logic [2:0] src;
    logic [2:0] dst;
  } dec_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: splits an 11-bit ROM word into fields and classifies it as ALU, move or NOP.
module instr_decode
  import seq_pkg::*;
#(
  parameter logic [4:0] MOVE_FUNCT = MOVE
) (
  input  logic [10:0] word_i,
  output dec_t        dec_o
);
  always_comb begin
    dec_o.funct   = word_i[FUNCT_HI:FUNCT_LO];
    dec_o.src     = word_i[SRC_HI:SRC_LO];
    dec_o.dst     = word_i[DST_HI:DST_LO];
    dec_o.is_alu  = word_i[FUNCT_LO];
    dec_o.is_move = !word_i[FUNCT_LO] && (word_i[FUNCT_HI:FUNCT_LO] == MOVE_FUNCT);
    dec_o.is_nop  = !dec_o.is_alu && !dec_o.is_move;
  end
endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: walks the instruction ROM, absorbs its read latency and issues decoded ops
// to the datapath over valid/ready.
module rom_sequencer
  import seq_pkg::*;
#(
  parameter int              ADDR_W     = 4,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(15),
  parameter bit              WRAP       = 1'b1,
  parameter logic [4:0]      MOVE_FUNCT = 5'b11010
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [10:0]       rom_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [4:0]        op_funct,
  output logic [2:0]        op_src,
  output logic [2:0]        op_dst,
  output logic              op_is_alu,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  dec_t              ir_q, ir_d, ld_dec;
  logic              stop_pend_q, stop_pend_d;
  logic              done_q, done_d;
  logic              adv, halt, at_last;
  logic              unused_ir;

  instr_decode #(.MOVE_FUNCT(MOVE_FUNCT)) u_dec (
    .word_i(rom_data),
    .dec_o (ld_dec)
  );

  assign at_last = (pc_q == LAST_ADDR);
  assign adv     = (state_q == LOAD && ld_dec.is_nop) || (state_q == ISSUE && op_ready);
  // a stop arriving on the advance cycle itself still halts here, giving one done pulse
  assign halt    = stop_pend_q || stop || (at_last && !WRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    stop_pend_d = stop_pend_q || (state_q != IDLE && stop);
    done_d      = 1'b0;
    if (state_q == IDLE && start && !stop) begin
      state_d = FETCH;
      pc_d    = '0;
    end
    if (state_q == FETCH) state_d = LOAD;
    if (state_q == LOAD) begin
      ir_d    = ld_dec;
      state_d = ISSUE;
    end
    if (adv) begin
      pc_d        = (halt || at_last) ? '0 : pc_q + 1'b1;
      state_d     = halt ? IDLE : FETCH;
      done_d      = halt;
      stop_pend_d = 1'b0;
    end
  end

  always_comb begin
    op_valid = (state_q == ISSUE);
    busy     = (state_q != IDLE);
  end

  assign rom_addr  = pc_q;
  assign op_funct  = ir_q.funct;
  assign op_src    = ir_q.src;
  assign op_dst    = ir_q.dst;
  assign op_is_alu = ir_q.is_alu;
  assign done      = done_q;
  assign unused_ir = ir_q.is_move ^ ir_q.is_nop;
endmodule

// File: doc/rom_sequencer.md
Name: rom_sequencer

Overview:
- Program sequencer for the 16-entry, 11-bit instruction ROM.
- Drives the ROM address and absorbs the ROM's one-cycle registered read latency.
- Decodes each word {funct[4:0], src[2:0], dst[2:0]} and issues it to the register-file/ALU datapath over a valid/ready handshake.
- Sits between the ROM and the datapath; start/stop/done connect to top-level control.

Parameters:
- ADDR_W, 4, ROM address width.
- LAST_ADDR, 15, final program address.
- WRAP, 1, 1 = PC returns to 0 after LAST_ADDR and keeps running; 0 = stop and pulse done.
- MOVE_FUNCT, 5'b11010, funct code for register move.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin execution from address 0; honoured only in IDLE.
- stop  in  1  request halt after the current instruction completes.
- rom_addr  out  ADDR_W  ROM address, equals the PC register.
- rom_data  in  11  ROM read data, valid the cycle after rom_addr is sampled.
- op_valid  out  1  decoded operation presented.
- op_ready  in  1  datapath accepts the operation.
- op_funct  out  5  instruction funct field.
- op_src  out  3  source register select.
- op_dst  out  3  destination register select.
- op_is_alu  out  1  1 = ALU op (funct[0]==1); 0 = move.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on program end or on a completed stop.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, pc=0, instruction register=0, stop_pend=0.
  - All outputs 0.
- Instruction register drives op_funct, op_src and op_dst; these are held stable while op_valid=1.
- FSM states: IDLE, FETCH, LOAD, ISSUE.
- IDLE:
  - start=1 -> pc=0, go to FETCH.
  - start=0 -> remain in IDLE.
- FETCH:
  - Lasts one cycle; the ROM samples rom_addr at the end of this cycle.
  - Always go to LOAD.
- LOAD:
  - Capture rom_data into the instruction register.
  - Classify the word:
    - funct[0]==1 -> ALU op.
    - funct==MOVE_FUNCT -> move.
    - Anything else (including 11'h000) -> NOP.
  - ALU op or move -> go to ISSUE.
  - NOP -> advance the PC (rule below) without asserting op_valid.
- ISSUE:
  - op_valid=1 until a cycle with op_valid && op_ready; the op transfers on that cycle.
  - On transfer, drop op_valid next cycle and advance the PC.
- Issue latency: FETCH at cycle N, LOAD at N+1, op_valid high from N+2. Best case is 3 cycles per instruction with op_ready tied high; a NOP costs 2 cycles.
- PC advance:
  - pc<LAST_ADDR -> pc+1, go to FETCH.
  - pc==LAST_ADDR and WRAP=1 -> pc=0, go to FETCH.
  - pc==LAST_ADDR and WRAP=0 -> pc=0, pulse done, go to IDLE.
- Stop handling:
  - stop is sampled in any non-IDLE state and sets stop_pend.
  - At the next PC-advance point: pc=0, pulse done, clear stop_pend, go to IDLE.
  - An in-flight ISSUE is never abandoned.
- Simultaneous events:
  - stop together with the program-end advance -> a single done pulse.
  - start and stop together in IDLE -> start ignored, remain in IDLE.
  - start outside IDLE -> ignored.
- op_ready while op_valid=0 -> ignored.
- rst_n low mid-ISSUE -> op_valid drops immediately (asynchronous); no transfer counted.
- busy = (state != IDLE).

Decomposition:
- Shared package seq_pkg holds:
  - State enum.
  - Funct constants matching the ROM encoding: NULLS, ONES, NO, NOT, XOR, XNOR, INCR, DECR, COMPL, ADD, SUBTR, MOVE.
  - Field slice constants: FUNCT=[10:6], SRC=[5:3], DST=[2:0].
- One natural sub-module: instr_decode, combinational, word -> {is_alu, is_move, is_nop, fields}. Everything else lives in rom_sequencer.

Test Plan:
- Reset then start with a ROM model returning {5'b11010,3'd4,3'd2} at addr 0 and op_ready=1:
  - rom_addr=0.
  - op_valid high 2 cycles after FETCH, with op_funct=11010, op_src=4, op_dst=2, op_is_alu=0.
- ROM word {5'b11001,3'd0,3'd3} with op_ready held low 5 cycles:
  - op_valid and fields stable for all 5 cycles.
  - Exactly one transfer, then rom_addr=pc+1.
- Addr 0 holds 11'h000 (NOP):
  - op_valid never asserts for it.
  - rom_addr steps 0->1 two cycles after FETCH.
- WRAP=0 with all 16 words valid and op_ready=1:
  - Exactly 16 transfers, then one done pulse.
  - pc=0, busy=0.
- WRAP=1: the transfer at addr 15 is followed by FETCH at addr 0.
- stop asserted mid-ISSUE at addr 5:
  - Addr-5 op completes; no fetch of addr 6.
  - done pulses, state returns to IDLE.
- rst_n pulled low with op_valid=1: op_valid=0 and busy=0 without a clock edge; pc=0.
